// File: rtl/fpnew_pipe_out.sv
// Output retiming stage: NumPipeRegs elastic valid/ready register stages with flush.
// Optional sticky status accumulation is enabled by defining FPNEW_PIPE_OUT_FLAG_ACCUM_EN.
module fpnew_pipe_out #(
  parameter int unsigned Width       = 32,
  parameter int unsigned NumPipeRegs = 0,
  parameter int unsigned TagWidth    = 1,
  parameter int unsigned AuxWidth    = 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [Width-1:0]    result_i,
  input  logic [4:0]          status_i,
  input  logic                extension_bit_i,
  input  logic [TagWidth-1:0] tag_i,
  input  logic [AuxWidth-1:0] aux_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic                flush_i,
  output logic [Width-1:0]    result_o,
  output logic [4:0]          status_o,
  output logic                extension_bit_o,
  output logic [TagWidth-1:0] tag_o,
  output logic [AuxWidth-1:0] aux_o,
  output logic                out_valid_o,
  input  logic                out_ready_i,
`ifdef FPNEW_PIPE_OUT_FLAG_ACCUM_EN
  input  logic                clear_flags_i,
  output logic [4:0]          fflags_o,
`endif
  output logic                busy_o
);

  localparam int unsigned PayW = Width + 6 + TagWidth + AuxWidth;

  logic [PayW-1:0] w_pay_in;
  logic [PayW-1:0] w_pay_out;

  assign w_pay_in = {result_i, status_i, extension_bit_i, tag_i, aux_i};
  assign {result_o, status_o, extension_bit_o, tag_o, aux_o} = w_pay_out;

`ifdef FPNEW_PIPE_OUT_FLAG_ACCUM_EN
  logic w_out_xfer;
`endif

  if (NumPipeRegs == 0) begin : g_bypass
    assign w_pay_out   = w_pay_in;
    assign out_valid_o = in_valid_i;
    assign in_ready_o  = out_ready_i;
    assign busy_o      = 1'b0;
`ifdef FPNEW_PIPE_OUT_FLAG_ACCUM_EN
    assign w_out_xfer  = in_valid_i & out_ready_i;
`endif
  end else begin : g_pipe
    logic [NumPipeRegs:1]   r_valid;
    logic [PayW-1:0]        r_data [1:NumPipeRegs];
    logic [NumPipeRegs-1:0] w_ready;
    logic [NumPipeRegs:0]   w_valid;
    logic [PayW-1:0]        w_data [0:NumPipeRegs];
    logic                   w_rdy_acc;

    // Stage i may load if the consumer is ready or any later stage is empty.
    always_comb begin
      w_rdy_acc = out_ready_i;
      w_ready   = '0;
      for (int i = NumPipeRegs; i >= 1; i--) begin
        w_rdy_acc    = w_rdy_acc | ~r_valid[i];
        w_ready[i-1] = w_rdy_acc;
      end
    end

    always_comb begin
      w_valid    = {r_valid, in_valid_i};
      w_data[0]  = w_pay_in;
      for (int i = 1; i <= NumPipeRegs; i++) begin
        w_data[i] = r_data[i];
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        r_valid <= '0;
        for (int i = 1; i <= NumPipeRegs; i++) begin
          r_data[i] <= '0;
        end
      end else begin
        for (int i = 1; i <= NumPipeRegs; i++) begin
          if (w_ready[i-1]) begin
            r_valid[i] <= w_valid[i-1] & ~flush_i;
            // Data only moves with a valid entry so bubbles never toggle it.
            if (w_valid[i-1]) begin
              r_data[i] <= w_data[i-1];
            end
          end else if (flush_i) begin
            r_valid[i] <= 1'b0;
          end
        end
      end
    end

    assign in_ready_o  = w_ready[0];
    assign out_valid_o = w_valid[NumPipeRegs];
    assign w_pay_out   = w_data[NumPipeRegs];
    assign busy_o      = |r_valid;
`ifdef FPNEW_PIPE_OUT_FLAG_ACCUM_EN
    // An entry leaving on a flush edge is considered killed.
    assign w_out_xfer  = out_valid_o & out_ready_i & ~flush_i;
`endif
  end

`ifdef FPNEW_PIPE_OUT_FLAG_ACCUM_EN
  logic [4:0] r_fflags;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_fflags <= '0;
    end else if (clear_flags_i) begin
      r_fflags <= w_out_xfer ? status_o : 5'b0;
    end else if (w_out_xfer) begin
      r_fflags <= r_fflags | status_o;
    end
  end

  assign fflags_o = r_fflags;
`endif

endmodule
